// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and state type for the ramlpm port arbiter.
//   RAM_ADDR_W / RAM_DATA_W / RAM_DEPTH : geometry of the 32x8 ramlpm block.
//   arb_state_t                         : arbiter FSM states (CLEAR sweep, SERVE requests).
package ram_pkg;

    localparam int unsigned RAM_ADDR_W = 5;
    localparam int unsigned RAM_DATA_W = 8;
    localparam int unsigned RAM_DEPTH  = 32;

    typedef enum logic {
        CLEAR,
        SERVE
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
//   clock, resetn : clock and asynchronous active-low reset.
//   req[1:0]      : request lines.
//   en            : grants are suppressed while low.
//   gnt[1:0]      : combinational one-hot grant.
// The priority pointer ptr_q names the requester that wins a tie; it flips to the
// other requester after every grant and holds when nothing is granted.
module rr_arb2
    import ram_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single-port ramlpm block between requester 0
// (switch/KEY path) and requester 1 (internal engine).
//   clock, resetn                  : clock (also clocks ramlpm), async active-low reset.
//   req*/we*/addr*/wdata*          : per-requester access, held until gnt*.
//   gnt0, gnt1                     : combinational grant, access is on the RAM pins this cycle.
//   rvalid0, rvalid1               : registered, rdata valid for that requester.
//   rdata                          : pass-through of ram_q.
//   busy                           : high while the power-up clear sweep runs.
//   ram_addr/ram_data/ram_wren     : drive ramlpm; ram_q is its output.
// Optional feature: define RAM_ARB_CLEAR_EN to compile in the power-up sweep that
// writes zero to every address before the first grant.
module ram_port_arbiter
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned DEPTH  = RAM_DEPTH
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("DEPTH must equal 2**ADDR_W");
    end

`ifdef RAM_ARB_CLEAR_EN
    localparam arb_state_t        ResetState = CLEAR;
    localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(DEPTH - 1);
    logic [ADDR_W-1:0] clr_addr_q;
`else
    localparam arb_state_t ResetState = SERVE;
`endif

    arb_state_t state_q;
    logic [1:0] gnt;
    logic       arb_en;
    logic       rvalid0_q;
    logic       rvalid1_q;
    logic       wren_c;

    // Grants are also blocked while reset is held so a pending req cannot slip through.
    assign arb_en = resetn && (state_q == SERVE);

    rr_arb2 u_rr_arb2 (
        .clock  (clock),
        .resetn (resetn),
        .req    ({req1, req0}),
        .en     (arb_en),
        .gnt    (gnt)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ResetState;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
`ifdef RAM_ARB_CLEAR_EN
            clr_addr_q <= '0;
`endif
        end else begin
            rvalid0_q <= gnt[0] & ~we0;
            rvalid1_q <= gnt[1] & ~we1;
`ifdef RAM_ARB_CLEAR_EN
            if (state_q == CLEAR) begin
                clr_addr_q <= clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == LastAddr) begin
                    state_q <= SERVE;
                end
            end
`endif
        end
    end

    always_comb begin
        wren_c   = 1'b0;
        ram_addr = '0;
        ram_data = '0;
`ifdef RAM_ARB_CLEAR_EN
        if (state_q == CLEAR) begin
            wren_c   = 1'b1;
            ram_addr = clr_addr_q;
        end else
`endif
        if (gnt[0]) begin
            wren_c   = we0;
            ram_addr = addr0;
            ram_data = wdata0;
        end else if (gnt[1]) begin
            wren_c   = we1;
            ram_addr = addr1;
            ram_data = wdata1;
        end
    end

    // The sweep state would otherwise drive wren high during reset.
    assign ram_wren = wren_c & resetn;

`ifdef RAM_ARB_CLEAR_EN
    assign busy = (state_q == CLEAR);
`else
    assign busy = 1'b0;
`endif

    assign gnt0    = gnt[0];
    assign gnt1    = gnt[1];
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter with a behavioural ramlpm.
// Read responses are queued when a read grant is expected and checked by a
// separate monitor when rvalid0/rvalid1 appear. Honours RAM_ARB_CLEAR_EN.
module tb_ram_port_arbiter;

    logic       clock = 1'b0;
    logic       resetn;
    logic       req0, req1, we0, we1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren;
    logic [7:0] rdata, ram_data, ram_q;
    logic [4:0] ram_addr;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

`ifdef RAM_ARB_CLEAR_EN
    localparam logic [7:0] D7 = 8'h00;
    localparam logic [7:0] D3 = 8'h00;
    localparam logic [7:0] D4 = 8'h00;
    localparam logic [7:0] D9 = 8'h00;
    localparam logic       BUSY_RST = 1'b1;
`else
    localparam logic [7:0] D7 = 8'h16;
    localparam logic [7:0] D3 = 8'h0A;
    localparam logic [7:0] D4 = 8'h0D;
    localparam logic [7:0] D9 = 8'h5C;
    localparam logic       BUSY_RST = 1'b0;
`endif

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    ram_port_arbiter dut (
        .clock    (clock),
        .resetn   (resetn),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .busy     (busy),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q)
    );

    // ramlpm model: registered read, write committed at the edge; seeded with i*3+1.
    logic [7:0] mem [32];
    logic       seeded = 1'b0;
    always @(posedge clock) begin
        if (!seeded) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 3 + 1);
            seeded <= 1'b1;
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_data;
        end
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic expect_gnt(input logic g0, input logic g1, input logic [7:0] rd,
                              input string tag);
        chk({tag, ".gnt0"}, 32'(gnt0), 32'(g0));
        chk({tag, ".gnt1"}, 32'(gnt1), 32'(g1));
        if (g0 && !we0) q0.push_back('{data: rd, cyc: cyc + 1});
        if (g1 && !we1) q1.push_back('{data: rd, cyc: cyc + 1});
    endtask

    task automatic sweep_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            smp();
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            chk({tag, ".addr"}, 32'(ram_addr), 32'(i));
            chk({tag, ".wren"}, 32'(ram_wren), 32'd1);
            chk({tag, ".data"}, 32'(ram_data), 32'd0);
            chk({tag, ".gnt0"}, 32'(gnt0), 32'd0);
            if (i != n - 1) nxt();
        end
    endtask

    // Response monitor.
    always @(negedge clock) begin
        exp_t e;
        if (rvalid0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL rvalid0_unexpected: got rvalid0=1 want 0 (cycle %0d)", cyc);
            end else begin
                e = q0.pop_front();
                if (rdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL rvalid0_resp: got %02h at cycle %0d want %02h at cycle %0d",
                             rdata, cyc, e.data, e.cyc);
                end
            end
        end
        if (rvalid1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL rvalid1_unexpected: got rvalid1=1 want 0 (cycle %0d)", cyc);
            end else begin
                e = q1.pop_front();
                if (rdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL rvalid1_resp: got %02h at cycle %0d want %02h at cycle %0d",
                             rdata, cyc, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        resetn = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd7; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 5'd0; wdata1 = 8'h00;
        repeat (3) @(posedge clock);
        smp();
        chk("rst.gnt0", 32'(gnt0), 32'd0);
        chk("rst.gnt1", 32'(gnt1), 32'd0);
        chk("rst.rvalid0", 32'(rvalid0), 32'd0);
        chk("rst.rvalid1", 32'(rvalid1), 32'd0);
        chk("rst.wren", 32'(ram_wren), 32'd0);
        chk("rst.addr", 32'(ram_addr), 32'd0);
        chk("rst.busy", 32'(busy), 32'(BUSY_RST));
        nxt();
        resetn = 1'b1;
`ifdef RAM_ARB_CLEAR_EN
        sweep_check(18, "sweep_a");
        #1 resetn = 1'b0;
        #1 chk("midrst.wren", 32'(ram_wren), 32'd0);
        nxt();
        nxt();
        resetn = 1'b1;
        sweep_check(32, "sweep_b");
        nxt();
`endif
        smp();
        expect_gnt(1'b1, 1'b0, D7, "first");
        chk("first.busy", 32'(busy), 32'd0);
        chk("first.addr", 32'(ram_addr), 32'd7);

        // Write then read the same address on consecutive cycles.
        nxt(); we0 = 1'b1; addr0 = 5'd5; wdata0 = 8'hA7;
        smp(); expect_gnt(1'b1, 1'b0, 8'h00, "wr5");
        chk("wr5.wren", 32'(ram_wren), 32'd1);
        chk("wr5.addr", 32'(ram_addr), 32'd5);
        chk("wr5.data", 32'(ram_data), 32'hA7);
        nxt(); we0 = 1'b0;
        smp(); expect_gnt(1'b1, 1'b0, 8'hA7, "rd5");
        chk("rd5.wren", 32'(ram_wren), 32'd0);
        nxt(); req0 = 1'b0;
        smp(); expect_gnt(1'b0, 1'b0, 8'h00, "idle");
        chk("idle.wren", 32'(ram_wren), 32'd0);
        chk("idle.addr", 32'(ram_addr), 32'd0);
        chk("idle.data", 32'(ram_data), 32'd0);

        // Requester 1 write, then read back.
        nxt(); req1 = 1'b1; we1 = 1'b1; addr1 = 5'd31; wdata1 = 8'hFF;
        smp(); expect_gnt(1'b0, 1'b1, 8'h00, "wr31");
        chk("wr31.wren", 32'(ram_wren), 32'd1);
        chk("wr31.addr", 32'(ram_addr), 32'd31);
        chk("wr31.data", 32'(ram_data), 32'hFF);
        nxt(); we1 = 1'b0;
        smp(); expect_gnt(1'b0, 1'b1, 8'hFF, "rd31");

        // Contention from ptr=0: grants alternate 0,1,0,1.
        nxt(); req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3; addr1 = 5'd4;
        for (int k = 0; k < 4; k++) begin
            smp();
            expect_gnt(k[0] == 1'b0, k[0] == 1'b1, k[0] ? D4 : D3, $sformatf("contend%0d", k));
            chk($sformatf("contend%0d.addr", k), 32'(ram_addr), k[0] ? 32'd4 : 32'd3);
            if (k < 3) nxt();
        end

        // Write via req0 (ptr -> 1), then a read cancelled by reset.
        nxt(); req1 = 1'b0; we0 = 1'b1; addr0 = 5'd9; wdata0 = 8'h5C;
        smp(); expect_gnt(1'b1, 1'b0, 8'h00, "wr9");
        nxt(); we0 = 1'b0;
        smp(); chk("cancel.gnt0_pre", 32'(gnt0), 32'd1);
        #1 resetn = 1'b0;
        #1 chk("cancel.gnt0", 32'(gnt0), 32'd0);
        chk("cancel.wren", 32'(ram_wren), 32'd0);
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd4;
        nxt();
        smp(); chk("cancel.rvalid0", 32'(rvalid0), 32'd0);
        chk("cancel.gnt1", 32'(gnt1), 32'd0);
        nxt();
        resetn = 1'b1;
`ifdef RAM_ARB_CLEAR_EN
        sweep_check(32, "sweep_c");
        nxt();
`endif
        // ptr is back at 0, so requester 0 wins the tie first.
        smp(); expect_gnt(1'b1, 1'b0, D9, "post_rst_a");
        nxt();
        smp(); expect_gnt(1'b0, 1'b1, D4, "post_rst_b");
        nxt(); req0 = 1'b0; req1 = 1'b0;
        smp(); expect_gnt(1'b0, 1'b0, 8'h00, "idle2");
        chk("idle2.busy", 32'(busy), 32'd0);
        nxt();
        nxt();
        smp();
        chk("q0.drained", 32'(q0.size()), 32'd0);
        chk("q1.drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
